// File: rtl/example_aligner_pkg.sv
// Shared constants and types for the K28.5 comma word aligner.
package example_aligner_pkg;

  // K28.5 in both running disparities, bit 0 = bit 'a' (first on the wire).
  localparam logic [9:0] COMMA_RDN = 10'h17C;
  localparam logic [9:0] COMMA_RDP = 10'h283;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } aligner_state_t;

  function automatic logic is_comma(input logic [9:0] word);
    return (word == COMMA_RDN) || (word == COMMA_RDP);
  endfunction

endpackage

// File: rtl/example_comma_finder.sv
// Combinational comma search over all ten bit offsets of a 20-bit window.
// Candidate k is w[k+9:k]; w[0] is the oldest received bit.
module example_comma_finder
  import example_aligner_pkg::*;
(
  input  logic [19:0] w,
  output logic [9:0]  hit,
  output logic [3:0]  first,
  output logic        any
);

  // Per-offset comma match.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      hit[k] = is_comma(w[k +: 10]);
    end
  end

  // Lowest matching offset; scanning downwards lets the lowest index win.
  always_comb begin
    // NOTE: assign a default before any conditional write so no path leaves
    // the output unassigned, which would otherwise infer a latch.
    first = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) first = 4'(k);
    end
  end

  assign any = |hit;

endmodule

// File: rtl/example_comma_aligner.sv
// Receive word aligner: finds the K28.5 offset in the unaligned transceiver
// stream, locks after LOCK_COUNT commas at one offset, and drops lock after
// UNLOCK_COUNT consecutive misaligned commas or on a realign request.
module example_comma_aligner
  import example_aligner_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       realign,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       comma_det,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int CNT_TOP = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  aligner_state_t   state_q, state_d;
  logic [9:0]       prev_q, prev_d;
  logic [3:0]       offset_q, offset_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [9:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             comma_det_q, comma_det_d;

  logic [19:0]      window;
  logic [9:0]       hit;
  logic [3:0]       first;
  logic             any;
  logic             hit_at_off;
  logic [9:0]       aligned;
  logic [CNT_W-1:0] good_inc, bad_inc;

  assign window = {data_in, prev_q};

  example_comma_finder u_finder (
    .w     (window),
    .hit   (hit),
    .first (first),
    .any   (any)
  );

  assign hit_at_off = hit[offset_q];
  assign good_inc   = (good_q == CNT_SAT) ? good_q : good_q + CNT_ONE;
  assign bad_inc    = (bad_q  == CNT_SAT) ? bad_q  : bad_q  + CNT_ONE;

  // Barrel select of the word at the current (pre-update) offset.
  always_comb begin
    aligned = window[9:0];
    for (int k = 0; k < 10; k++) begin
      if (offset_q == 4'(k)) aligned = window[k +: 10];
    end
  end

  // Next-state logic: search / check / locked, realign overrides everything.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    good_d   = good_q;
    bad_d    = bad_q;
    prev_d   = data_in;

    if (realign) begin
      state_d = SEARCH;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (any) begin
            offset_d = first;
            good_d   = CNT_ONE;
            if (LOCK_COUNT == 1) begin
              state_d = LOCKED;
              bad_d   = '0;
            end else begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          // A comma at the current offset beats any simultaneous one elsewhere.
          if (hit_at_off) begin
            good_d = good_inc;
            if (good_inc >= LOCK_TGT) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else if (any) begin
            offset_d = first;
            good_d   = CNT_ONE;
          end
        end
        LOCKED: begin
          if (hit_at_off) begin
            bad_d = '0;
          end else if (any) begin
            bad_d = bad_inc;
            if (bad_inc >= UNLOCK_TGT) begin
              // Offset is kept until the next search hit replaces it.
              state_d = SEARCH;
              good_d  = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Output word and flags, all from pre-update offset and state.
  always_comb begin
    data_out_d   = aligned;
    data_valid_d = (state_q == LOCKED);
    comma_det_d  = hit_at_off & (state_q == LOCKED);
  end

  // All state and the output register; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      prev_q       <= '0;
      offset_q     <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      comma_det_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      prev_q       <= prev_d;
      offset_q     <= offset_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      comma_det_q  <= comma_det_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign comma_det  = comma_det_q;
  assign locked     = (state_q == LOCKED);
  assign offset     = offset_q;

endmodule
